// File: rtl/seg7_decoder.sv
// Registered hex-to-seven-segment decoder for one display digit.
// Segment order gfedcba; lamp_test beats blank, and reset beats both.
module seg7_decoder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] leds
);

  localparam logic [6:0] AllLit  = 7'h7F;
  localparam logic [6:0] AllDark = 7'h00;
  localparam logic [6:0] DarkDrive = ACTIVE_LOW ? ~AllDark : AllDark;

  logic [6:0] w_glyph;
  logic [6:0] w_pattern;
  logic [6:0] w_drive;
  logic [6:0] r_leds;

  // Active-high glyphs; b and d are lower case so they differ from 8 and 0.
  always_comb begin
    w_glyph = AllDark;
    case (bcd)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
      default: w_glyph = AllDark;
    endcase
  end

  always_comb begin
    w_pattern = w_glyph;
    if (lamp_test) begin
      w_pattern = AllLit;
    end else if (blank) begin
      w_pattern = AllDark;
    end
    w_drive = ACTIVE_LOW ? ~w_pattern : w_pattern;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds <= DarkDrive;
    end else begin
      r_leds <= w_drive;
    end
  end

  assign leds = r_leds;

endmodule

// File: tb/tb_seg7_decoder.sv
// Scoreboard bench: driver pushes hand-computed expectations for both polarities,
// monitor pops and compares one cycle later.
module tb_seg7_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;
  logic [6:0] leds_al1;
  logic [6:0] leds_al0;

  logic [6:0] q_al1[$];
  logic [6:0] q_al0[$];
  string      q_name[$];

  int n_vec;
  int n_bad;
  bit driver_done;

  seg7_decoder #(.ACTIVE_LOW(1'b1)) u_dut_al1 (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
    .leds      (leds_al1)
  );

  seg7_decoder #(.ACTIVE_LOW(1'b0)) u_dut_al0 (
    .clk       (clk),
    .reset     (reset),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
    .leds      (leds_al0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge; the result is due on the next rising edge.
  task automatic step(input string name, input logic rst, input logic lt, input logic bl,
                      input logic [3:0] d, input logic [6:0] exp1, input logic [6:0] exp0);
    @(negedge clk);
    reset     = rst;
    lamp_test = lt;
    blank     = bl;
    bcd       = d;
    q_al1.push_back(exp1);
    q_al0.push_back(exp0);
    q_name.push_back(name);
  endtask

  // Monitor: output is registered, so a fresh value is present after every edge.
  always @(posedge clk) begin
    #1;
    if (q_al1.size() != 0) begin
      logic [6:0] e1;
      logic [6:0] e0;
      string      nm;
      e1 = q_al1.pop_front();
      e0 = q_al0.pop_front();
      nm = q_name.pop_front();
      n_vec = n_vec + 1;
      if (leds_al1 !== e1) begin
        n_bad = n_bad + 1;
        $display("FAIL %s (ACTIVE_LOW=1): leds=%02h expected=%02h", nm, leds_al1, e1);
      end
      n_vec = n_vec + 1;
      if (leds_al0 !== e0) begin
        n_bad = n_bad + 1;
        $display("FAIL %s (ACTIVE_LOW=0): leds=%02h expected=%02h", nm, leds_al0, e0);
      end
    end
  end

  logic [6:0] sweep_al1 [16];
  logic [6:0] sweep_al0 [16];

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    driver_done = 1'b0;
    reset       = 1'b1;
    lamp_test   = 1'b0;
    blank       = 1'b0;
    bcd         = 4'h8;

    sweep_al1 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sweep_al0 = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reset with bcd=8 pending, then release.
    step("reset_hold", 1'b1, 1'b0, 1'b0, 4'h8, 7'h7F, 7'h00);
    step("reset_hold2", 1'b1, 1'b0, 1'b0, 4'h8, 7'h7F, 7'h00);
    step("reset_release", 1'b0, 1'b0, 1'b0, 4'h8, 7'h00, 7'h7F);

    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_%h", i[3:0]), 1'b0, 1'b0, 1'b0, i[3:0], sweep_al1[i], sweep_al0[i]);
    end

    // Overrides on bcd=1.
    step("digit1", 1'b0, 1'b0, 1'b0, 4'h1, 7'h79, 7'h06);
    step("blank", 1'b0, 1'b0, 1'b1, 4'h1, 7'h7F, 7'h00);
    step("lamp_test", 1'b0, 1'b1, 1'b0, 4'h1, 7'h00, 7'h7F);
    step("lamp_and_blank", 1'b0, 1'b1, 1'b1, 4'h1, 7'h00, 7'h7F);
    step("overrides_clear", 1'b0, 1'b0, 1'b0, 4'h1, 7'h79, 7'h06);

    // Back-to-back alternation 3/E.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step("alt_3", 1'b0, 1'b0, 1'b0, 4'h3, 7'h30, 7'h4F);
      else            step("alt_E", 1'b0, 1'b0, 1'b0, 4'hE, 7'h06, 7'h79);
    end

    // Mid-operation reset with lamp_test: reset wins, dark.
    step("reset_over_lamp", 1'b1, 1'b1, 1'b0, 4'hA, 7'h7F, 7'h00);
    step("after_reset_A", 1'b0, 1'b0, 1'b0, 4'hA, 7'h08, 7'h77);
    step("digit_F", 1'b0, 1'b0, 1'b0, 4'hF, 7'h0E, 7'h71);
    step("reset_mid", 1'b1, 1'b0, 1'b1, 4'h0, 7'h7F, 7'h00);
    step("after_reset_0", 1'b0, 1'b0, 1'b0, 4'h0, 7'h40, 7'h3F);

    driver_done = 1'b1;
    // Bounded drain of the scoreboard.
    for (int k = 0; k < 5 && q_al1.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (q_al1.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d entries left, expected 0", q_al1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
